// File: rtl/washer_controller.sv
// rtl/washer_controller.sv - washer cycle sequencer FSM with pause/resume and registered Moore outputs.
// Optional macro WASHER_EXTRA_RINSE_EN adds a second rinse pass before SPIN.
module washer_controller (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic       pause,
  input  logic       door_closed,
  input  logic [1:0] load_sel,
  input  logic       Td,
  input  logic       Tf,
  input  logic       Tr,
  input  logic       Ts,
  input  logic       Tw,
  output logic       tmr_R,
  output logic       tmr_hold,
  output logic [1:0] tmr_load,
  output logic       water_valve,
  output logic       motor,
  output logic       drain_pump,
  output logic       spin,
  output logic       door_lock,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN, DONE, PAUSED
  } state_t;

  state_t state;
  state_t saved;
  state_t next;
  logic   active;
  logic   flags_ok;

`ifdef WASHER_EXTRA_RINSE_EN
  logic rinse_cnt;
`endif

  assign active = (state == FILL) || (state == WASH) || (state == DRAIN) ||
                  (state == RFILL) || (state == RINSE) || (state == RDRAIN) ||
                  (state == SPIN);

  // Timer flags are stale during the entry cycle while the timer is being cleared.
  assign flags_ok = !tmr_R;

  always_comb begin
    next = state;
    if (active && pause) begin
      next = PAUSED;
    end else begin
      case (state)
        IDLE:   if (start && door_closed) next = FILL;
        FILL:   if (flags_ok && Tf) next = WASH;
        WASH:   if (flags_ok && Tw) next = DRAIN;
        DRAIN:  if (flags_ok && Td) next = RFILL;
        RFILL:  if (flags_ok && Tf) next = RINSE;
        RINSE:  if (flags_ok && Tr) next = RDRAIN;
        RDRAIN: begin
          if (flags_ok && Td) begin
`ifdef WASHER_EXTRA_RINSE_EN
            next = rinse_cnt ? SPIN : RFILL;
`else
            next = SPIN;
`endif
          end
        end
        SPIN:   if (flags_ok && Ts) next = DONE;
        DONE:   if (!door_closed) next = IDLE;
        PAUSED: if (!pause && door_closed) next = saved;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state       <= IDLE;
      saved       <= IDLE;
      tmr_R       <= 1'b1;
      tmr_hold    <= 1'b0;
      tmr_load    <= 2'b00;
      water_valve <= 1'b0;
      motor       <= 1'b0;
      drain_pump  <= 1'b0;
      spin        <= 1'b0;
      door_lock   <= 1'b0;
      done        <= 1'b0;
`ifdef WASHER_EXTRA_RINSE_EN
      rinse_cnt   <= 1'b0;
`endif
    end else begin
      state    <= next;
      tmr_R    <= (next != state);
      tmr_hold <= (next == PAUSED);
      if (state == IDLE && next == FILL)
        tmr_load <= (load_sel == 2'b11) ? 2'b10 : load_sel;
      if (next == PAUSED && state != PAUSED)
        saved <= state;
`ifdef WASHER_EXTRA_RINSE_EN
      if (state == IDLE && next == FILL)
        rinse_cnt <= 1'b0;
      else if (state == RDRAIN && next == RFILL)
        rinse_cnt <= 1'b1;
`endif
      // Outputs are decoded from the state being entered so they line up with it.
      water_valve <= (next == FILL) || (next == RFILL);
      motor       <= (next == WASH) || (next == RINSE) || (next == SPIN);
      drain_pump  <= (next == DRAIN) || (next == RDRAIN) || (next == SPIN);
      spin        <= (next == SPIN);
      door_lock   <= (next == FILL) || (next == WASH) || (next == DRAIN) ||
                     (next == RFILL) || (next == RINSE) || (next == RDRAIN) ||
                     (next == SPIN);
      done        <= (next == DONE);
    end
  end

endmodule

// File: tb/tb_washer_controller.sv
// tb/tb_washer_controller.sv - scoreboard bench for washer_controller with a behavioural phase timer.
module tb_washer_controller;

  logic       clk = 1'b0;
  logic       R;
  logic       start;
  logic       pause;
  logic       door_closed;
  logic [1:0] load_sel;
  logic       Td, Tf, Tr, Ts, Tw;
  logic       tmr_R, tmr_hold;
  logic [1:0] tmr_load;
  logic       water_valve, motor, drain_pump, spin, door_lock, done;

  logic       tf_force = 1'b0;
  logic       td_force = 1'b0;
  logic [7:0] tcnt = 8'd0;
  logic [7:0] wlen;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  washer_controller dut (
    .clk(clk), .R(R), .start(start), .pause(pause), .door_closed(door_closed),
    .load_sel(load_sel), .Td(Td), .Tf(Tf), .Tr(Tr), .Ts(Ts), .Tw(Tw),
    .tmr_R(tmr_R), .tmr_hold(tmr_hold), .tmr_load(tmr_load),
    .water_valve(water_valve), .motor(motor), .drain_pump(drain_pump),
    .spin(spin), .door_lock(door_lock), .done(done)
  );

  always #5 clk = ~clk;

  // Phase timer: cleared by tmr_R, so in phase cycle n (entry = 1) tcnt = n-1.
  always @(posedge clk) begin
    if (tmr_R) tcnt <= 8'd1;
    else if (!tmr_hold) tcnt <= tcnt + 8'd1;
  end

  assign wlen = (tmr_load == 2'b00) ? 8'd3 : (tmr_load == 2'b01) ? 8'd5 : 8'd9;
  assign Tf = (tcnt == 8'd3) | tf_force;
  assign Td = (tcnt == 8'd2) | td_force;
  assign Tr = (tcnt == 8'd5);
  assign Ts = (tcnt == 8'd8);
  assign Tw = (tcnt == wlen);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: plain run, 1: forced Tf/Td glitches, 2: pause in WASH cycle 3
  task automatic run(input logic [1:0] ls, input int mode);
    int r, visits, fills, dur, ev, ef;
    dur = (ls == 2'b00) ? 33 : (ls == 2'b01) ? 35 : 39;
    ev  = 2;
    ef  = 8;
    if (mode == 2) begin
      dur += 5;
      ev  += 1;
    end
`ifdef WASHER_EXTRA_RINSE_EN
    dur += 13;
    ev  += 1;
    ef  += 4;
`endif
    exp_q.push_back(dur);
    exp_q.push_back(ev);
    exp_q.push_back(ef);
    exp_q.push_back((ls == 2'b11) ? 2 : int'(ls));

    @(negedge clk);
    load_sel = ls;
    start = 1'b1;
    door_closed = 1'b1;
    if (mode == 1) tf_force = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fill_entry", {water_valve, tmr_R, door_lock}, 3'b111);
    r = 0;
    visits = 0;
    fills = 0;
    while (!done && r < 400) begin
      tf_force = (mode == 1) && (r == 0);
      td_force = (mode == 1) && (r == 5 || r == 6);
      pause    = (mode == 2) && (r == 6 || r == 7);
      if (tmr_R && motor && !spin) visits++;
      if (water_valve) fills++;
      if (mode == 2 && r == 7)
        check("paused", {tmr_hold, door_lock, motor, water_valve, drain_pump}, 5'b10000);
      if (mode == 2 && r == 9)
        check("resume", {tmr_R, motor, tmr_hold}, 3'b110);
      if (mode == 2 && r == 10)
        check("resume_tmr_R_low", tmr_R, 0);
      @(negedge clk);
      r++;
    end
    tf_force = 1'b0;
    td_force = 1'b0;
    pause = 1'b0;
    check("done_latency", r, exp_q.pop_front());
    check("wash_rinse_visits", visits, exp_q.pop_front());
    check("fill_cycles", fills, exp_q.pop_front());
    check("tmr_load", tmr_load, exp_q.pop_front());
    check("done_outputs", {done, door_lock, motor}, 3'b100);
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    check("done_ignores_start", {done, door_lock, tmr_hold}, 3'b100);
    start = 1'b0;
    pause = 1'b0;
    door_closed = 1'b0;
    @(negedge clk);
    check("done_to_idle", {done, door_lock}, 2'b00);
    door_closed = 1'b1;
  endtask

  initial begin
    int n;
    R = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    door_closed = 1'b1;
    load_sel = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_tmr_R", tmr_R, 1);
    check("rst_outputs", {tmr_hold, water_valve, motor, drain_pump, spin, door_lock, done}, 0);
    check("rst_tmr_load", tmr_load, 0);
    R = 1'b0;
    @(negedge clk);
    check("release_tmr_R", tmr_R, 0);
    check("release_idle", {door_lock, water_valve, done}, 0);

    door_closed = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("start_door_open", {water_valve, door_lock, tmr_R}, 0);
    start = 1'b0;
    door_closed = 1'b1;

    pause = 1'b1;
    repeat (2) @(negedge clk);
    check("pause_idle", {tmr_hold, door_lock}, 0);
    pause = 1'b0;

    run(2'b00, 0);
    run(2'b01, 0);
    run(2'b10, 0);
    run(2'b11, 0);
    run(2'b00, 1);
    run(2'b00, 2);

    @(negedge clk);
    load_sel = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!spin && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_spin", spin, 1);
    R = 1'b1;
    #1;
    check("rst_spin_outputs", {water_valve, motor, drain_pump, spin, door_lock, done, tmr_hold}, 0);
    check("rst_spin_tmr_R", tmr_R, 1);
    check("rst_spin_tmr_load", tmr_load, 0);
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    check("rst_spin_release", {tmr_R, door_lock, motor}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/washer_controller.md
WASHER_CONTROLLER -- requirements
Module: washer_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port list: name  direction  width  meaning.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 R  in  1  asynchronous active-high reset.
REQ-004 start  in  1  level; begins a cycle from IDLE.
REQ-005 pause  in  1  level; requests pause of an active cycle.
REQ-006 door_closed  in  1  door sensor, 1 = closed.
REQ-007 load_sel  in  2  load size: 00 small, 01 medium, 10 large, 11 treated as 10.
REQ-008 Td, Tf, Tr, Ts, Tw  in  1 each  timer expiry flags: drain, fill, rinse, spin, wash.
REQ-009 tmr_R  out  1  timer counter clear.
REQ-010 tmr_hold  out  1  timer hold request, 1 while PAUSED.
REQ-011 tmr_load  out  2  latched wash length code to timer.
REQ-012 water_valve, motor, drain_pump, spin, door_lock, done  out  1 each  actuator and status outputs.

Function
REQ-013 States SHALL be IDLE, FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN, DONE, PAUSED; the 4-bit register is Moore-decoded.
REQ-014 IDLE->FILL SHALL occur when start=1 and door_closed=1; start with door_closed=0 is ignored.
REQ-015 On IDLE->FILL, tmr_load SHALL latch load_sel (11 -> 10) and hold it until the next IDLE->FILL.
REQ-016 Sequence: FILL -Tf-> WASH -Tw-> DRAIN -Td-> RFILL -Tf-> RINSE -Tr-> RDRAIN -Td-> SPIN -Ts-> DONE.
REQ-017 tmr_R SHALL be a registered signal, high for exactly the first cycle of every newly entered state (including resume), low otherwise.
REQ-018 Timer flags SHALL be ignored while tmr_R=1; only the flag named for the current state is acted on.
REQ-019 State durations, entry cycle included: FILL/RFILL 4, WASH 4/6/10 for load 00/01/10, DRAIN/RDRAIN 3, RINSE 6, SPIN 9.
REQ-020 Outputs: FILL/RFILL water_valve; WASH/RINSE motor; DRAIN/RDRAIN drain_pump; SPIN motor+spin+drain_pump; DONE done.
REQ-021 door_lock SHALL be 1 in FILL..SPIN and 0 in IDLE, PAUSED, DONE.
REQ-022 pause=1 in any state FILL..SPIN SHALL move to PAUSED next cycle and store the interrupted state; pause outranks a same-cycle timer flag.
REQ-023 In PAUSED, all actuators SHALL be 0 and tmr_hold=1.
REQ-024 PAUSED SHALL return to the stored state when pause=0 and door_closed=1, restarting that phase from its entry cycle.
REQ-025 pause SHALL be ignored in IDLE and DONE.
REQ-026 DONE->IDLE SHALL occur when door_closed=0; start is ignored in DONE.

Reset
REQ-027 While R=1: state IDLE, tmr_R=1, tmr_hold=0, tmr_load=00, stored state IDLE, rinse count 0, all actuators and done 0.
REQ-028 Reset asserted mid-cycle SHALL abort immediately; the first cycle after release SHALL be IDLE with tmr_R=0.

Configuration
REQ-029 Macro WASHER_EXTRA_RINSE_EN defined: RDRAIN -Td-> RFILL once more (1-bit rinse count) before SPIN, adding 13 cycles.
REQ-030 Macro undefined: RDRAIN -Td-> SPIN always; no rinse count register is synthesized.

Verification
REQ-031 R pulse, then load_sel=00, start=1, door_closed=1 for one cycle -> FILL next cycle, DONE entered 33 cycles after FILL entry, done=1.
REQ-032 Same with load_sel=01 / 10 / 11 -> DONE after 35 / 39 / 39 cycles; tmr_load=10 for 11.
REQ-033 pause=1 for 2 cycles in WASH cycle 3 -> PAUSED, tmr_hold=1, door_lock=0; on release WASH restarts, tmr_R=1 one cycle.
REQ-034 Tf forced high during FILL entry cycle -> ignored, FILL still lasts 4 cycles; Td forced during WASH -> no transition.
REQ-035 R asserted in SPIN -> all outputs 0, tmr_R=1 the same cycle; start with door_closed=0 -> stays IDLE.
REQ-036 WASHER_EXTRA_RINSE_EN defined, load_sel=00 -> DONE 46 cycles after FILL entry; two RINSE visits observed.
